// File: rtl/nx_bit_stream_pack.sv
// rtl/nx_bit_stream_pack.sv - variable-length chunk packer into fixed-width words
// Residual bits live in the low end of buf_q; a whole accepted chunk is staged there while draining.
module nx_bit_stream_pack #(
   parameter int IN_W  = 256,
   parameter int OUT_W = 64,
   parameter int ACC_W = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [IN_W-1:0]            in_data_i,
   input  logic [$clog2(IN_W)+1-1:0]  in_size_i,
   input  logic                       in_flush_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [OUT_W-1:0]           out_data_o,
   output logic [$clog2(OUT_W)+1-1:0] out_bits_o,
   output logic                       out_last_o
);
   localparam int TOT_W = IN_W + ACC_W;
   localparam int ISZ_W = $clog2(IN_W) + 1;
   localparam int OB_SH = $clog2(OUT_W);
   localparam int OB_W  = OB_SH + 1;
   localparam int SZ_W  = $clog2(TOT_W) + 1;
   localparam int SLOTS = TOT_W / OUT_W;
   localparam logic [OB_W-1:0] FULL_BITS = OB_W'(OUT_W);

   typedef enum logic [1:0] {ACCEPT, DRAIN, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [TOT_W-1:0]     buf_q, buf_d;
   logic [OB_W-1:0]      acc_size_q, acc_size_d;
   logic [SZ_W-1:0]      cnt_q, cnt_d;
   logic [OB_SH-1:0]     rem_q, rem_d;
   logic [SZ_W-1:0]      idx_q, idx_d;
   logic                 flush_pend_q, flush_pend_d;

   logic [IN_W-1:0]      in_mask;
   logic [TOT_W-1:0]     acc_mask;
   logic [TOT_W-1:0]     tot;
   logic [SZ_W-1:0]      sz;
   logic [SZ_W-1:0]      cnt_new;
   logic [SZ_W-1:0]      last_idx;
   logic                 last_word;
   logic [OUT_W-1:0]     word;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ACCEPT;
         buf_q        <= '0;
         acc_size_q   <= '0;
         cnt_q        <= '0;
         rem_q        <= '0;
         idx_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         acc_size_q   <= acc_size_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
         idx_q        <= idx_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      acc_size_d   = acc_size_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      idx_d        = idx_q;
      flush_pend_d = flush_pend_q;
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
      out_data_o   = '0;
      out_bits_o   = '0;
      out_last_o   = 1'b0;

      in_mask   = ~({IN_W{1'b1}} << in_size_i);
      acc_mask  = ~({TOT_W{1'b1}} << acc_size_q);
      tot       = (buf_q & acc_mask) | ({{ACC_W{1'b0}}, in_data_i & in_mask} << acc_size_q);
      sz        = SZ_W'(acc_size_q) + SZ_W'(in_size_i);
      cnt_new   = sz >> OB_SH;
      last_idx  = cnt_q - SZ_W'(1);
      last_word = (idx_q == last_idx);
      word      = '0;
      for (int k = 0; k < SLOTS; k++) begin
         if (idx_q == SZ_W'(k)) word = buf_q[k*OUT_W +: OUT_W];
      end

      case (state_q)
         ACCEPT: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               buf_d = tot;
               if (cnt_new != '0) begin
                  cnt_d        = cnt_new;
                  rem_d        = sz[OB_SH-1:0];
                  idx_d        = '0;
                  flush_pend_d = in_flush_i;
                  state_d      = DRAIN;
               end else begin
                  acc_size_d = sz[OB_W-1:0];
                  if (in_flush_i) state_d = FLUSH;
               end
            end
         end
         DRAIN: begin
            out_valid_o = 1'b1;
            out_data_o  = word;
            out_bits_o  = FULL_BITS;
            out_last_o  = flush_pend_q && (rem_q == '0) && last_word;
            if (out_ready_i) begin
               idx_d = idx_q + SZ_W'(1);
               if (last_word) begin
                  // Residual bits above rem are already zero because tot was masked on accept.
                  buf_d      = buf_q >> {cnt_q, {OB_SH{1'b0}}};
                  acc_size_d = {1'b0, rem_q};
                  idx_d      = '0;
                  state_d    = (flush_pend_q && (rem_q != '0)) ? FLUSH : ACCEPT;
               end
            end
         end
         FLUSH: begin
            out_valid_o = 1'b1;
            out_data_o  = buf_q[OUT_W-1:0];
            out_bits_o  = acc_size_q;
            out_last_o  = 1'b1;
            if (out_ready_i) begin
               buf_d      = '0;
               acc_size_d = '0;
               state_d    = ACCEPT;
            end
         end
         default: state_d = ACCEPT;
      endcase
   end

   a_in_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
      in_valid_i |-> (in_size_i <= ISZ_W'(IN_W)));

endmodule
